// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and instruction memory.
// The fetch unit drives req/addr; memory returns rdata together with ready.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the architectural PC and the F->D pipeline register.
// Branch delay slot semantics: a redirect never squashes the instruction already in flight.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    if_fetch_unit_if.master         imem,
    output logic [31:0]             F_PC,
    output logic [31:0]             D_PC,
    output logic [31:0]             D_instr,
    output logic                    D_valid,
    output logic                    D_adel
);

    typedef enum logic {StRun, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        d_adel_q, d_adel_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic addr_ok;
    logic done;
    logic advance;

    always_comb begin
        addr_ok = (f_pc_q[1:0] == 2'b00) && (f_pc_q >= IM_BASE) && (f_pc_q <= IM_LIMIT);
        // An illegal address completes immediately without touching memory.
        done    = !addr_ok || imem.ready;
        advance = done && !stall;
    end

    assign imem.req  = addr_ok;
    assign imem.addr = f_pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (addr_ok && !imem.ready) state_d = StWait;
            StWait:  if (imem.ready || !addr_ok) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        f_pc_d       = f_pc_q;
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_valid_d    = d_valid_q;
        d_adel_d     = d_adel_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        if (advance) begin
            if (pend_valid_q) begin
                f_pc_d = pend_pc_q;
            end else if (redirect_valid) begin
                f_pc_d = redirect_pc;
            end else begin
                f_pc_d = f_pc_q + 32'd4;
            end
            d_pc_d       = f_pc_q;
            d_instr_d    = addr_ok ? imem.rdata : 32'h0;
            d_adel_d     = !addr_ok;
            d_valid_d    = 1'b1;
            pend_valid_d = 1'b0;
        end else begin
            // Hold the redirect until the delay-slot instruction actually moves into D.
            if (redirect_valid) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = redirect_pc;
            end
            if (!stall) begin
                d_valid_d = 1'b0;
                d_instr_d = 32'h0;
                d_adel_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            f_pc_q       <= RESET_PC;
            d_pc_q       <= 32'h0;
            d_instr_q    <= 32'h0;
            d_valid_q    <= 1'b0;
            d_adel_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            f_pc_q       <= f_pc_d;
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_valid_q    <= d_valid_d;
            d_adel_q     <= d_adel_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign F_PC    = f_pc_q;
    assign D_PC    = d_pc_q;
    assign D_instr = d_instr_q;
    assign D_valid = d_valid_q;
    assign D_adel  = d_adel_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns {16'hC0DE, addr[15:0]} for every word.
// Expected values are hand-derived cycle by cycle.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_adel;

    integer errors;
    integer checks;

    if_fetch_unit_if bus ();

    assign bus.rdata = {16'hC0DE, bus.addr[15:0]};

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .F_PC           (F_PC),
        .D_PC           (D_PC),
        .D_instr        (D_instr),
        .D_valid        (D_valid),
        .D_adel         (D_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        bus.ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({F_PC, D_PC, D_instr} !== {32'h3000, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h exp 3000 0 0", F_PC, D_PC, D_instr);
        end
        checks++;
        if ({D_valid, D_adel, bus.req, bus.addr} !== {1'b0, 1'b0, 1'b1, 32'h3000}) begin
            errors++;
            $display("FAIL reset_flags got v=%b a=%b req=%b addr=%h exp 0 0 1 3000",
                     D_valid, D_adel, bus.req, bus.addr);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid} !== {32'h3004, 32'h3000, 32'hC0DE3000, 1'b1}) begin
            errors++;
            $display("FAIL stream1 got %h %h %h %b exp 3004 3000 c0de3000 1",
                     F_PC, D_PC, D_instr, D_valid);
        end
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid} !== {32'h3008, 32'h3004, 32'hC0DE3004, 1'b1}) begin
            errors++;
            $display("FAIL stream2 got %h %h %h %b exp 3008 3004 c0de3004 1",
                     F_PC, D_PC, D_instr, D_valid);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({F_PC, D_PC, D_instr} !== {32'h3100, 32'h3008, 32'hC0DE3008}) begin
            errors++;
            $display("FAIL redirect_slot got %h %h %h exp 3100 3008 c0de3008",
                     F_PC, D_PC, D_instr);
        end
    endtask

    task automatic test_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h3004;
        tick();
        redirect_valid = 1'b0;
        bus.ready = 1'b0;
        tick();
        checks++;
        if ({bus.req, bus.addr, D_valid, D_instr} !== {1'b1, 32'h3004, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL wait_bubble1 got req=%b addr=%h v=%b i=%h exp 1 3004 0 0",
                     bus.req, bus.addr, D_valid, D_instr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h3200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({bus.addr, F_PC, D_PC, D_valid} !== {32'h3004, 32'h3004, 32'h3100, 1'b0}) begin
            errors++;
            $display("FAIL wait_hold got addr=%h f=%h d=%h v=%b exp 3004 3004 3100 0",
                     bus.addr, F_PC, D_PC, D_valid);
        end
        tick();
        checks++;
        if ({bus.addr, D_valid} !== {32'h3004, 1'b0}) begin
            errors++;
            $display("FAIL wait_bubble3 got addr=%h v=%b exp 3004 0", bus.addr, D_valid);
        end
        bus.ready = 1'b1;
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid} !== {32'h3200, 32'h3004, 32'hC0DE3004, 1'b1}) begin
            errors++;
            $display("FAIL wait_release got %h %h %h %b exp 3200 3004 c0de3004 1",
                     F_PC, D_PC, D_instr, D_valid);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3300;
        tick();
        checks++;
        if ({F_PC, D_PC, D_valid} !== {32'h3200, 32'h3004, 1'b1}) begin
            errors++;
            $display("FAIL stall1 got %h %h %b exp 3200 3004 1", F_PC, D_PC, D_valid);
        end
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr} !== {32'h3200, 32'h3004, 32'hC0DE3004}) begin
            errors++;
            $display("FAIL stall2 got %h %h %h exp 3200 3004 c0de3004", F_PC, D_PC, D_instr);
        end
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr} !== {32'h3300, 32'h3200, 32'hC0DE3200}) begin
            errors++;
            $display("FAIL stall_release got %h %h %h exp 3300 3200 c0de3200",
                     F_PC, D_PC, D_instr);
        end
        tick();
        checks++;
        if ({F_PC, D_PC} !== {32'h3304, 32'h3300}) begin
            errors++;
            $display("FAIL stall_no_double got %h %h exp 3304 3300", F_PC, D_PC);
        end
    endtask

    task automatic test_adel();
        redirect_valid = 1'b1; redirect_pc = 32'h3002;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({F_PC, bus.req} !== {32'h3002, 1'b0}) begin
            errors++;
            $display("FAIL adel_misalign_req got f=%h req=%b exp 3002 0", F_PC, bus.req);
        end
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid, D_adel} !==
            {32'h3006, 32'h3002, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL adel_misalign got %h %h %h v=%b a=%b exp 3006 3002 0 1 1",
                     F_PC, D_PC, D_instr, D_valid, D_adel);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h7000;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({F_PC, bus.req, D_PC, D_adel} !== {32'h7000, 1'b0, 32'h3006, 1'b1}) begin
            errors++;
            $display("FAIL adel_limit_req got f=%h req=%b d=%h a=%b exp 7000 0 3006 1",
                     F_PC, bus.req, D_PC, D_adel);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h3400;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid, D_adel} !==
            {32'h3400, 32'h7000, 32'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL adel_limit got %h %h %h v=%b a=%b exp 3400 7000 0 1 1",
                     F_PC, D_PC, D_instr, D_valid, D_adel);
        end
        tick();
        checks++;
        if ({D_PC, D_instr, D_adel, bus.req} !== {32'h3400, 32'hC0DE3400, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL adel_recover got %h %h a=%b req=%b exp 3400 c0de3400 0 1",
                     D_PC, D_instr, D_adel, bus.req);
        end
    endtask

    task automatic test_reset_in_wait();
        // F_PC is 0x3404 here; park in WAIT with a redirect pending.
        bus.ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3500;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({bus.req, bus.addr, D_valid} !== {1'b1, 32'h3404, 1'b0}) begin
            errors++;
            $display("FAIL rstwait_pre got req=%b addr=%h v=%b exp 1 3404 0",
                     bus.req, bus.addr, D_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid, D_adel, bus.addr} !==
            {32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h3000}) begin
            errors++;
            $display("FAIL rstwait_async got %h %h %h v=%b a=%b addr=%h exp 3000 0 0 0 0 3000",
                     F_PC, D_PC, D_instr, D_valid, D_adel, bus.addr);
        end
        bus.ready = 1'b1;
        #2 reset = 1'b0;
        tick();
        checks++;
        if ({F_PC, D_PC, D_instr, D_valid} !== {32'h3004, 32'h3000, 32'hC0DE3000, 1'b1}) begin
            errors++;
            $display("FAIL rstwait_restart got %h %h %h %b exp 3004 3000 c0de3000 1",
                     F_PC, D_PC, D_instr, D_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_redirect();
        test_wait();
        test_stall();
        test_adel();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
